timer_us_multi: RTL and testbench

Multi-channel microsecond timer: one shared prescaler derives a 1 µs tick (scaled by `TICK_US`) from `clk_36MHz`, and `CHANNELS` independent down-counters count those ticks. Each channel runs one-shot or periodic and emits a single-cycle expiry pulse on `q[i]`. It replaces the single fixed `timer_1us` in game-logic timing: alien march cadence, shot cooldown, UFO spawn and similar delays.

---
 rtl/timer_us_multi.sv | 152 +++++++++++++++
 tb/tb_timer_us_multi.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_us_multi.sv
// ---------------------------------------------------------------------------
// timer_us_multi
//
// Multi-channel microsecond timer for game-logic timing. This includes alien
// march cadence, shot cooldown, UFO spawn delay and similar jobs.
//
// One shared prescaler divides clk_36MHz down to a tick strobe. The tick
// fires once every DIV enabled cycles, where DIV = CLK_FREQ_HZ/1e6*TICK_US.
// CHANNELS independent down-counters consume that tick. Each channel runs
// either one-shot or periodic. On expiry it emits a one-cycle pulse on q[i].
//
// Parameters
//   CLK_FREQ_HZ  input clock frequency, an integer multiple of 1 MHz
//   TICK_US      tick period in microseconds
//   CHANNELS     number of independent channels (1..16)
//   WIDTH        counter / period width per channel
//
// Ports
//   clk_36MHz  in   system clock, rising edge
//   reset      in   asynchronous active-high reset, clears all state
//   en         in   global enable; low freezes the prescaler (channels pause)
//   load       in   [CHANNELS]        per-channel start/restart strobe
//   stop       in   [CHANNELS]        per-channel abort strobe
//   mode       in   [CHANNELS]        1 = periodic, 0 = one-shot
//   period     in   [CHANNELS*WIDTH]  channel i period at [i*WIDTH +: WIDTH]
//   tick       out  registered one-cycle tick strobe
//   q          out  [CHANNELS]        registered one-cycle expiry pulse
//   busy       out  [CHANNELS]        channel i is running
//   count      out  [CHANNELS*WIDTH]  remaining ticks per channel
// ---------------------------------------------------------------------------
module timer_us_multi #(
  parameter int CLK_FREQ_HZ = 36_000_000,
  parameter int TICK_US     = 1,
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 16
) (
  input  logic                      clk_36MHz,
  input  logic                      reset,
  input  logic                      en,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS-1:0]       stop,
  input  logic [CHANNELS-1:0]       mode,
  input  logic [CHANNELS*WIDTH-1:0] period,
  output logic                      tick,
  output logic [CHANNELS-1:0]       q,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS*WIDTH-1:0] count
);

  localparam int DIV   = CLK_FREQ_HZ / 1_000_000 * TICK_US;
  localparam int PRE_W = $clog2(DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  logic [PRE_W-1:0] pre;

  // Shared prescaler.
  // While enabled, pre counts 0..DIV-1 and then wraps. The wrap edge raises
  // tick for exactly one cycle. Dropping en holds pre where it is instead of
  // clearing it. This lets a paused channel resume with the same phase.
  // tick is forced low while paused so that no channel can advance.
  always_ff @(posedge clk_36MHz or posedge reset) begin
    if (reset) begin
      pre  <= '0;
      tick <= 1'b0;
    end else if (en) begin
      if (pre == PRE_LAST) begin
        pre  <= '0;
        tick <= 1'b1;
      end else begin
        pre  <= pre + PRE_W'(1);
        tick <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    state_t           state_r, state_n;
    logic [WIDTH-1:0] cnt_r, cnt_n;
    logic             mode_r, mode_n;
    logic             q_r, q_n;
    logic [WIDTH-1:0] period_i;

    assign period_i = period[i*WIDTH +: WIDTH];

    // Channel state register.
    // This includes the latched mode and the registered expiry pulse, so
    // q[i] comes straight from a flop and is glitch-free.
    always_ff @(posedge clk_36MHz or posedge reset) begin
      if (reset) begin
        state_r <= IDLE;
        cnt_r   <= '0;
        mode_r  <= 1'b0;
        q_r     <= 1'b0;
      end else begin
        state_r <= state_n;
        cnt_r   <= cnt_n;
        mode_r  <= mode_n;
        q_r     <= q_n;
      end
    end

    // Channel next-state logic. Priority is stop, then load, then tick.
    // A load that coincides with a tick swallows that tick, so a fresh load
    // always starts from the full period. A zero period can never run: on
    // load, or on a periodic reload, it parks the channel in IDLE. The
    // count > 1 test keeps the counter from ever wrapping below zero.
    always_comb begin
      state_n = state_r;
      cnt_n   = cnt_r;
      mode_n  = mode_r;
      q_n     = 1'b0;
      if (stop[i]) begin
        state_n = IDLE;
        cnt_n   = '0;
      end else if (load[i]) begin
        if (period_i != '0) begin
          state_n = RUN;
          cnt_n   = period_i;
          mode_n  = mode[i];
        end else begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end else if ((state_r == RUN) && tick) begin
        if (cnt_r > WIDTH'(1)) begin
          cnt_n = cnt_r - WIDTH'(1);
        end else begin
          q_n = 1'b1;
          if (mode_r && (period_i != '0)) begin
            cnt_n  = period_i;
            mode_n = mode[i];
          end else begin
            state_n = IDLE;
            cnt_n   = '0;
          end
        end
      end
    end

    assign q[i]                    = q_r;
    assign busy[i]                 = (state_r == RUN);
    assign count[i*WIDTH +: WIDTH] = cnt_r;
  end

endmodule

// File: tb/tb_timer_us_multi.sv
// ---------------------------------------------------------------------------
// tb_timer_us_multi
//
// Directed self-checking bench for timer_us_multi with default parameters.
// The defaults give DIV = 36, 4 channels and 16-bit counters. Every expected
// value is a hand-computed constant in units of clock edges.
// ---------------------------------------------------------------------------
module tb_timer_us_multi;

  logic        clk_36MHz = 1'b0;
  logic        reset     = 1'b1;
  logic        en        = 1'b1;
  logic [3:0]  load      = '0;
  logic [3:0]  stop      = '0;
  logic [3:0]  mode      = '0;
  logic [63:0] period    = '0;
  logic        tick;
  logic [3:0]  q;
  logic [3:0]  busy;
  logic [63:0] count;

  int assertions = 0;
  int failures   = 0;

  timer_us_multi #(
    .CLK_FREQ_HZ(36_000_000),
    .TICK_US    (1),
    .CHANNELS   (4),
    .WIDTH      (16)
  ) dut (
    .clk_36MHz(clk_36MHz),
    .reset    (reset),
    .en       (en),
    .load     (load),
    .stop     (stop),
    .mode     (mode),
    .period   (period),
    .tick     (tick),
    .q        (q),
    .busy     (busy),
    .count    (count)
  );

  // 100 MHz simulation clock; only edge counts matter
  always #5 clk_36MHz = ~clk_36MHz;

  // Hard stop in case something wedges
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it
  task automatic step();
    @(posedge clk_36MHz);
    #1;
  endtask

  // Pulse load/stop across exactly one rising edge
  task automatic applyStimulus(input logic [3:0] ld, input logic [3:0] st);
    load = ld;
    stop = st;
    step();
    load = '0;
    stop = '0;
  endtask

  task automatic wait_tick(input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!tick && n < budget);
  endtask

  task automatic wait_q(input int ch, input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!q[ch] && n < budget);
  endtask

  task automatic watch(input int n, input logic [3:0] qmask,
                       output int qhits, output int tickhits);
    qhits    = 0;
    tickhits = 0;
    for (int k = 0; k < n; k++) begin
      step();
      if ((q & qmask) != 4'b0) qhits++;
      if (tick) tickhits++;
    end
  endtask

  initial begin
    int n;
    int qh;
    int th;
    int first_tick;

    // ---------------- reset state ----------------
    step();
    step();
    checkOutput("rst_tick",  {63'b0, tick}, 64'd0);
    checkOutput("rst_q",     {60'b0, q},    64'd0);
    checkOutput("rst_busy",  {60'b0, busy}, 64'd0);
    checkOutput("rst_count", count,         64'd0);
    reset = 1'b0;

    // ---------------- prescaler cadence ----------------
    wait_tick(100, n);
    checkOutput("first_tick", n, 36);
    wait_tick(100, n);
    checkOutput("second_tick", n, 36);
    watch(108, 4'hF, qh, th);
    checkOutput("tick_count_108", th, 3);
    checkOutput("idle_q", qh, 0);
    checkOutput("idle_busy", {60'b0, busy}, 64'd0);

    // ---------------- ch0 one-shot, period 3, load on tick edge ----------------
    wait_tick(100, n);
    period[15:0] = 16'd3;
    mode[0]      = 1'b0;
    applyStimulus(4'b0001, 4'b0000);
    checkOutput("ch0_load_count", count[15:0], 3);
    checkOutput("ch0_load_busy", busy[0], 1);
    repeat (35) step();
    checkOutput("ch0_count_3", count[15:0], 3);
    step();
    checkOutput("ch0_count_2", count[15:0], 2);
    repeat (36) step();
    checkOutput("ch0_count_1", count[15:0], 1);
    wait_q(0, 100, n);
    checkOutput("ch0_expiry_delay", n, 36);
    checkOutput("ch0_busy_fall", busy[0], 0);
    checkOutput("ch0_count_0", count[15:0], 0);
    step();
    checkOutput("ch0_q_width", q[0], 0);
    watch(150, 4'b0001, qh, th);
    checkOutput("ch0_no_repeat", qh, 0);

    // ---------------- ch1 periodic, period 2, then 4 ----------------
    period[31:16] = 16'd2;
    mode[1]       = 1'b1;
    applyStimulus(4'b0010, 4'b0000);
    wait_q(1, 200, n);
    checkOutput("ch1_first_range", (n >= 37 && n <= 72), 1);
    for (int k = 0; k < 4; k++) begin
      wait_q(1, 200, n);
      checkOutput("ch1_interval_72", n, 72);
    end
    period[31:16] = 16'd4;
    wait_q(1, 200, n);
    checkOutput("ch1_interval_pre_reload", n, 72);
    wait_q(1, 300, n);
    checkOutput("ch1_interval_144", n, 144);
    checkOutput("ch1_busy_periodic", busy[1], 1);
    applyStimulus(4'b0000, 4'b0010);
    checkOutput("ch1_stop_busy", busy[1], 0);
    checkOutput("ch1_stop_count", count[31:16], 0);

    // ---------------- ch2 pause with en low for 100 cycles ----------------
    wait_tick(100, n);
    period[47:32] = 16'd5;
    mode[2]       = 1'b0;
    applyStimulus(4'b0100, 4'b0000);
    repeat (50) step();
    en = 1'b0;
    watch(100, 4'b0100, qh, th);
    checkOutput("en_low_no_tick", th, 0);
    checkOutput("en_low_busy", busy[2], 1);
    en = 1'b1;
    wait_q(2, 400, n);
    checkOutput("ch2_delayed_expiry", n, 130);

    // ---------------- ch3 simultaneous events / zero period ----------------
    period[63:48] = 16'd5;
    mode[3]       = 1'b0;
    applyStimulus(4'b1000, 4'b1000);
    checkOutput("ld_stop_busy", busy[3], 0);
    checkOutput("ld_stop_count", count[63:48], 0);
    period[63:48] = 16'd0;
    applyStimulus(4'b1000, 4'b0000);
    checkOutput("ld_zero_busy", busy[3], 0);
    period[63:48] = 16'd5;
    applyStimulus(4'b1000, 4'b0000);
    repeat (10) step();
    checkOutput("ch3_run_busy", busy[3], 1);
    period[63:48] = 16'd0;
    applyStimulus(4'b1000, 4'b0000);
    checkOutput("reload_zero_busy", busy[3], 0);
    checkOutput("reload_zero_count", count[63:48], 0);
    period[63:48] = 16'd2;
    mode[3]       = 1'b1;
    applyStimulus(4'b1000, 4'b0000);
    period[63:48] = 16'd0;
    wait_q(3, 200, n);
    checkOutput("ch3_zero_reload_q", (n >= 37 && n <= 72), 1);
    checkOutput("ch3_zero_reload_busy", busy[3], 0);
    checkOutput("ch3_zero_reload_count", count[63:48], 0);
    watch(200, 4'b1000, qh, th);
    checkOutput("ch3_no_q_after", qh, 0);

    // ---------------- async reset mid-count ----------------
    period = {16'd3, 16'd3, 16'd3, 16'd3};
    mode   = 4'b1111;
    applyStimulus(4'b1111, 4'b0000);
    repeat (50) step();
    wait_tick(100, n);
    reset = 1'b1;
    #1;
    checkOutput("async_tick",  {63'b0, tick}, 64'd0);
    checkOutput("async_q",     {60'b0, q},    64'd0);
    checkOutput("async_busy",  {60'b0, busy}, 64'd0);
    checkOutput("async_count", count,         64'd0);
    #1;
    reset = 1'b0;
    first_tick = 0;
    qh = 0;
    for (int k = 1; k <= 300; k++) begin
      step();
      if (tick && first_tick == 0) first_tick = k;
      if (q != 4'b0) qh++;
    end
    checkOutput("post_reset_first_tick", first_tick, 36);
    checkOutput("post_reset_no_q", qh, 0);
    checkOutput("post_reset_busy", {60'b0, busy}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
